tblink_rpc_call_initiator: RTL
==============================

TBLINK_RPC_CALL_INITIATOR -- requirements
Module: tblink_rpc_call_initiator

Interface
REQ-001 SHALL have parameter ID_W, default 2, call-id width; slot count NSLOT = 2**ID_W.
REQ-002 SHALL have parameter METHOD_W, default 8, method-id width.
REQ-003 SHALL have parameter DATA_W, default 32, params/retval width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, cycles a slot may wait for its response.
REQ-005 SHALL have port clock, in, 1: single clock; all logic is on the rising edge.
REQ-006 SHALL have port reset, in, 1: synchronous, active-high reset.
REQ-007 SHALL have ports req_valid/req_ready (in/out, 1), req_method (in, METHOD_W), req_params (in, DATA_W), req_blocking (in, 1): local call request.
REQ-008 SHALL have ports inv_valid/inv_ready (out/in, 1), inv_call_id (out, ID_W), inv_method (out, METHOD_W), inv_params (out, DATA_W), inv_blocking (out, 1): invoke toward endpoint.
REQ-009 SHALL have ports rsp_valid/rsp_ready (in/out, 1), rsp_call_id (in, ID_W), rsp_retval (in, DATA_W): invoke_rsp from endpoint.
REQ-010 SHALL have ports done_valid/done_ready (out/in, 1), done_call_id (out, ID_W), done_retval (out, DATA_W), done_error (out, 1): completion to requester.
REQ-011 SHALL have ports outstanding (out, ID_W+1): count of non-FREE slots; stray_rsp (out, 1): one-cycle pulse.

Function
REQ-012 SHALL complete a transfer on any valid/ready pair when both are high at a clock edge; valid SHALL NOT drop and payload SHALL stay stable until accepted.
REQ-013 SHALL keep each slot in state FREE, ISSUED (invoke not yet accepted) or WAIT (awaiting response).
REQ-014 SHALL drive req_ready = (!inv_valid || inv_ready) && (!req_blocking || any slot FREE).
REQ-015 On a blocking request accept, SHALL move the lowest-index FREE slot to ISSUED and load it as inv_call_id; inv_valid SHALL rise the next cycle (1-cycle latency).
REQ-016 SHALL not allocate a slot on a non-blocking request accept, SHALL drive inv_call_id = 0, and SHALL generate no done.
REQ-017 On an inv handshake for a blocking call, SHALL move that slot ISSUED->WAIT and clear its timer.
REQ-018 SHALL drive rsp_ready = !done_valid || done_ready.
REQ-019 On an accepted response whose slot is WAIT, SHALL load done with call_id, retval and error=0, and SHALL set the slot FREE.
REQ-020 On an accepted response whose slot is FREE or ISSUED, SHALL drop it, leave the slot unchanged and pulse stray_rsp for 1 cycle.
REQ-021 A slot freed in cycle N SHALL be allocatable from cycle N+1; allocation SHALL use the pre-edge FREE vector.
REQ-022 outstanding SHALL equal the registered count of non-FREE slots, saturating at NSLOT with no wrap.

Reset
REQ-023 While reset is high at an edge, SHALL set all slots FREE and clear all timers.
REQ-024 While reset is high at an edge, SHALL set req_ready=0, inv_valid=0, rsp_ready=0, done_valid=0, stray_rsp=0, outstanding=0, and clear all data outputs to 0.
REQ-025 Reset mid-transaction SHALL discard pending invokes and completions without emitting them.

Configuration
REQ-026 With TBLINK_RPC_CALL_TIMEOUT_EN defined, each WAIT slot timer SHALL increment every cycle, saturating at TIMEOUT_CYCLES.
REQ-027 With TBLINK_RPC_CALL_TIMEOUT_EN defined, a saturated slot SHALL go FREE and emit done with error=1 and retval=0 when the done register is available.
REQ-028 With TBLINK_RPC_CALL_TIMEOUT_EN defined, a response SHALL take priority over a timeout in the same cycle; a deferred timeout SHALL fire in a later cycle, lowest slot first.
REQ-029 With TBLINK_RPC_CALL_TIMEOUT_EN undefined, no timer logic SHALL exist, done_error SHALL be tied to 0, and WAIT SHALL persist indefinitely.

Verification
REQ-030 Bench SHALL cover: blocking request method=0x12, params=0xDEAD_BEEF, inv_ready=1 -> inv_call_id=0 one cycle later; rsp id 0, retval=5 -> done id 0, retval=5, error=0; outstanding 1->0.
REQ-031 Bench SHALL cover: four blocking requests with no responses -> ids 0,1,2,3, outstanding=4, req_ready=0 for a blocking request; a non-blocking request is still accepted.
REQ-032 Bench SHALL cover: responses in order 2,0 while done_ready=0 -> rsp_ready=0 after the first; done order 2 then 0 once done_ready=1.
REQ-033 Bench SHALL cover: rsp for FREE id 3 -> stray_rsp one-cycle pulse, no done, outstanding unchanged.
REQ-034 Bench SHALL cover, with TIMEOUT_EN and TIMEOUT_CYCLES=8: no response -> done error=1 retval=0 after 8 WAIT cycles; a response arriving the same cycle as saturation -> error=0.
REQ-035 Bench SHALL cover: reset asserted with inv_valid=1 and two slots WAIT -> after the edge all outputs are 0, and the next blocking call gets id 0.

Source files
------------

// File: rtl/tblink_rpc_call_initiator.sv
// Call initiator: tracks up to 2**ID_W outstanding blocking calls by call id, issues invokes and matches responses.
// Optional response timeout is compiled in with `define TBLINK_RPC_CALL_TIMEOUT_EN.
module tblink_rpc_call_initiator #(
    parameter int ID_W           = 2,
    parameter int METHOD_W       = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [METHOD_W-1:0]   req_method,
    input  logic [DATA_W-1:0]     req_params,
    input  logic                  req_blocking,

    output logic                  inv_valid,
    input  logic                  inv_ready,
    output logic [ID_W-1:0]       inv_call_id,
    output logic [METHOD_W-1:0]   inv_method,
    output logic [DATA_W-1:0]     inv_params,
    output logic                  inv_blocking,

    input  logic                  rsp_valid,
    output logic                  rsp_ready,
    input  logic [ID_W-1:0]       rsp_call_id,
    input  logic [DATA_W-1:0]     rsp_retval,

    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [ID_W-1:0]       done_call_id,
    output logic [DATA_W-1:0]     done_retval,
    output logic                  done_error,

    output logic [ID_W:0]         outstanding,
    output logic                  stray_rsp,
    output logic [2*(2**ID_W)-1:0] dbg_slot_state
);

    localparam int NSLOT = 2**ID_W;

    typedef enum logic [1:0] {
        SLOT_FREE   = 2'd0,
        SLOT_ISSUED = 2'd1,
        SLOT_WAIT   = 2'd2
    } slot_e;

    slot_e slot_q [NSLOT];

    logic            any_free;
    logic [ID_W-1:0] alloc_id;
    logic            req_fire;
    logic            alloc_fire;
    logic            inv_fire;
    logic            rsp_fire;
    logic            rsp_hit;
    logic            done_free;
    logic            to_fire;
    logic [ID_W-1:0] to_id;
    logic [ID_W+1:0] out_sum;

    // Lowest-index FREE slot from the pre-edge state; a slot freed this cycle is not visible until next cycle.
    always_comb begin
        any_free = 1'b0;
        alloc_id = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (slot_q[i] == SLOT_FREE) begin
                any_free = 1'b1;
                alloc_id = ID_W'(i);
            end
        end
    end

    // Every channel: a beat moves when valid && ready at a rising edge; valid holds and payload stays stable until then.
    assign req_ready  = !reset && (!inv_valid || inv_ready) && (!req_blocking || any_free);
    assign rsp_ready  = !reset && (!done_valid || done_ready);
    assign req_fire   = req_valid && req_ready;
    assign alloc_fire = req_fire && req_blocking;
    assign inv_fire   = inv_valid && inv_ready;
    assign rsp_fire   = rsp_valid && rsp_ready;
    assign rsp_hit    = rsp_fire && (slot_q[rsp_call_id] == SLOT_WAIT);
    assign done_free  = !done_valid || done_ready;

`ifdef TBLINK_RPC_CALL_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] timer_q [NSLOT];
    logic               any_sat;

    // A response loading done this cycle wins; a saturated slot simply waits for the next free cycle.
    always_comb begin
        any_sat = 1'b0;
        to_id   = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (slot_q[i] == SLOT_WAIT && timer_q[i] == TIMER_W'(TIMEOUT_CYCLES)) begin
                any_sat = 1'b1;
                to_id   = ID_W'(i);
            end
        end
        to_fire = any_sat && done_free && !rsp_hit;
    end
`else
    assign to_fire    = 1'b0;
    assign to_id      = '0;
    assign done_error = 1'b0;
`endif

    // Slot occupancy bookkeeping; at most one allocation and one release happen per cycle.
    always_comb begin
        out_sum = {1'b0, outstanding};
        if (alloc_fire) out_sum = out_sum + 1'b1;
        if (rsp_hit)    out_sum = out_sum - 1'b1;
        if (to_fire)    out_sum = out_sum - 1'b1;
        if (out_sum > (ID_W+2)'(NSLOT)) out_sum = (ID_W+2)'(NSLOT);
    end

    always_comb begin
        dbg_slot_state = '0;
        for (int i = 0; i < NSLOT; i++) begin
            dbg_slot_state[2*i +: 2] = slot_q[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NSLOT; i++) begin
                slot_q[i] <= SLOT_FREE;
`ifdef TBLINK_RPC_CALL_TIMEOUT_EN
                timer_q[i] <= '0;
`endif
            end
            inv_valid    <= 1'b0;
            inv_call_id  <= '0;
            inv_method   <= '0;
            inv_params   <= '0;
            inv_blocking <= 1'b0;
            done_valid   <= 1'b0;
            done_call_id <= '0;
            done_retval  <= '0;
`ifdef TBLINK_RPC_CALL_TIMEOUT_EN
            done_error   <= 1'b0;
`endif
            outstanding  <= '0;
            stray_rsp    <= 1'b0;
        end else begin
            stray_rsp   <= rsp_fire && !rsp_hit;
            outstanding <= out_sum[ID_W:0];

`ifdef TBLINK_RPC_CALL_TIMEOUT_EN
            for (int i = 0; i < NSLOT; i++) begin
                if (slot_q[i] == SLOT_WAIT && timer_q[i] != TIMER_W'(TIMEOUT_CYCLES)) begin
                    timer_q[i] <= timer_q[i] + 1'b1;
                end
            end
`endif

            // Invoke register: a new request can reload it in the same cycle the old invoke drains.
            if (req_fire) begin
                inv_valid    <= 1'b1;
                inv_call_id  <= req_blocking ? alloc_id : '0;
                inv_method   <= req_method;
                inv_params   <= req_params;
                inv_blocking <= req_blocking;
            end else if (inv_fire) begin
                inv_valid <= 1'b0;
            end

            if (alloc_fire) begin
                slot_q[alloc_id] <= SLOT_ISSUED;
            end

            if (inv_fire && inv_blocking) begin
                slot_q[inv_call_id] <= SLOT_WAIT;
`ifdef TBLINK_RPC_CALL_TIMEOUT_EN
                timer_q[inv_call_id] <= '0;
`endif
            end

            if (rsp_hit) begin
                slot_q[rsp_call_id] <= SLOT_FREE;
                done_valid          <= 1'b1;
                done_call_id        <= rsp_call_id;
                done_retval         <= rsp_retval;
`ifdef TBLINK_RPC_CALL_TIMEOUT_EN
                done_error          <= 1'b0;
`endif
            end else if (to_fire) begin
                slot_q[to_id] <= SLOT_FREE;
                done_valid    <= 1'b1;
                done_call_id  <= to_id;
                done_retval   <= '0;
`ifdef TBLINK_RPC_CALL_TIMEOUT_EN
                done_error    <= 1'b1;
`endif
            end else if (done_valid && done_ready) begin
                done_valid <= 1'b0;
            end
        end
    end

endmodule
